// File: rtl/we_event_monitor_if.sv
// WE event monitor host-side bundle.
// Event inputs, control pulses and readback outputs.
interface we_event_monitor_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = 4
);
  logic [N_CH-1:0]  ev_in;
  logic [N_CH-1:0]  rise_en;
  logic [N_CH-1:0]  clr_trig;
  logic [N_CH-1:0]  sticky_clr;
  logic             snap_trig;
  logic [SEL_W-1:0] rd_sel;
  logic [N_CH-1:0]  pulse_out;
  logic [N_CH-1:0]  sticky_out;
  logic [N_CH-1:0]  ovf;
  logic [CNT_W-1:0] cnt_live;
  logic [CNT_W-1:0] cnt_snap;

  modport master (
    output ev_in, rise_en, clr_trig,
    output sticky_clr, snap_trig, rd_sel,
    input  pulse_out, sticky_out, ovf,
    input  cnt_live, cnt_snap
  );

  modport slave (
    input  ev_in, rise_en, clr_trig,
    input  sticky_clr, snap_trig, rd_sel,
    output pulse_out, sticky_out, ovf,
    output cnt_live, cnt_snap
  );
endinterface

// File: rtl/we_event_monitor.sv
// N-channel event monitor: edge pulses, sticky bits,
// wrap/saturate counters and a coherent snapshot bank.
module we_event_monitor #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int SAT   = 0,
  parameter int SEL_W = 4
) (
  input  logic clk_512k,
  input  logic rst,
  we_event_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0]  ev_q;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  inc;
  logic [N_CH-1:0]  pulse_q;
  logic [N_CH-1:0]  sticky_q;
  logic [N_CH-1:0]  ovf_q;
  logic [N_CH-1:0]  ovf_d;
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [CNT_W-1:0] snap_q [N_CH];

  assign rise = bus.ev_in & ~ev_q;
  assign inc  = (bus.rise_en & rise)
              | (~bus.rise_en & bus.ev_in);

  // ev_q tracks the input even in reset, so a level
  // already high at release is not seen as an edge.
  always_ff @(posedge clk_512k) begin
    ev_q <= bus.ev_in;
  end

  // A clear coinciding with an event restarts at 1
  // so that event is still counted.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (bus.clr_trig[i]) begin
        cnt_d[i] = inc[i] ? CNT_ONE : '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = (SAT != 0) ? CNT_MAX : '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_512k) begin
    if (rst) begin
      pulse_q  <= '0;
      sticky_q <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      pulse_q  <= rise;
      sticky_q <= rise | (sticky_q & ~bus.sticky_clr);
      ovf_q    <= ovf_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (bus.snap_trig) begin
          snap_q[i] <= cnt_q[i];
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    bus.cnt_live = '0;
    bus.cnt_snap = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        bus.cnt_live = cnt_q[i];
        bus.cnt_snap = snap_q[i];
      end
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.sticky_out = sticky_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_we_event_monitor.sv
// Directed bench for we_event_monitor.
// Main 4-channel instance plus two 4-bit wrap/saturate instances.
module tb_we_event_monitor;

  logic clk_512k = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_512k = ~clk_512k;

  we_event_monitor_if #(.N_CH(4), .CNT_W(32), .SEL_W(4)) bus ();
  we_event_monitor_if #(.N_CH(1), .CNT_W(4),  .SEL_W(1)) bw ();
  we_event_monitor_if #(.N_CH(1), .CNT_W(4),  .SEL_W(1)) bs ();

  we_event_monitor #(
    .N_CH(4), .CNT_W(32), .SAT(0), .SEL_W(4)
  ) dut (
    .clk_512k(clk_512k), .rst(rst), .bus(bus)
  );

  we_event_monitor #(
    .N_CH(1), .CNT_W(4), .SAT(0), .SEL_W(1)
  ) dut_w (
    .clk_512k(clk_512k), .rst(rst), .bus(bw)
  );

  we_event_monitor #(
    .N_CH(1), .CNT_W(4), .SAT(1), .SEL_W(1)
  ) dut_s (
    .clk_512k(clk_512k), .rst(rst), .bus(bs)
  );

  task automatic tick();
    @(posedge clk_512k);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ev_in   = 4'b0101;
    bus.rise_en = 4'b1111;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ((bus.pulse_out | bus.sticky_out) !== 4'b0) begin
        errors++;
        $display("FAIL reset_quiet cyc %0d: pulse %b sticky %b want 0",
                 c, bus.pulse_out, bus.sticky_out);
      end
    end
    for (int s = 0; s < 4; s++) begin
      bus.rd_sel = 4'(s);
      #1;
      checks++;
      if (bus.cnt_live !== 32'd0 || bus.cnt_snap !== 32'd0) begin
        errors++;
        $display("FAIL reset_cnt sel %0d: live %0d snap %0d want 0",
                 s, bus.cnt_live, bus.cnt_snap);
      end
    end
    checks++;
    if (bus.ovf !== 4'b0 || bw.cnt_live !== 4'd0 || bs.cnt_live !== 4'd0) begin
      errors++;
      $display("FAIL reset_ovf: ovf %b w %0d s %0d want 0",
               bus.ovf, bw.cnt_live, bs.cnt_live);
    end
  endtask

  task automatic test_rise_count();
    int pulses;
    bus.ev_in   = 4'b0000;
    bus.rise_en = 4'b0001;
    repeat (2) tick();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      bus.ev_in = 4'b0001;
      tick();
      checks++;
      if (bus.pulse_out[0] !== 1'b1) begin
        errors++;
        $display("FAIL rise_pulse_hi %0d: got %b want 1", p, bus.pulse_out[0]);
      end
      tick();
      checks++;
      if (bus.pulse_out[0] !== 1'b0) begin
        errors++;
        $display("FAIL rise_pulse_lo %0d: got %b want 0", p, bus.pulse_out[0]);
      end
      bus.ev_in = 4'b0000;
      repeat (2) tick();
    end
    bus.rd_sel = 4'd0;
    #1;
    checks++;
    if (bus.cnt_live !== 32'd3) begin
      errors++;
      $display("FAIL rise_cnt: got %0d want 3", bus.cnt_live);
    end
    checks++;
    if (bus.sticky_out !== 4'b0001) begin
      errors++;
      $display("FAIL rise_sticky: got %b want 0001", bus.sticky_out);
    end
  endtask

  task automatic test_level_count();
    int pulses;
    pulses = 0;
    bus.ev_in = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bus.pulse_out[1] === 1'b1) pulses++;
    end
    bus.ev_in = 4'b0000;
    tick();
    if (bus.pulse_out[1] === 1'b1) pulses++;
    bus.rd_sel = 4'd1;
    #1;
    checks++;
    if (bus.cnt_live !== 32'd7) begin
      errors++;
      $display("FAIL level_cnt: got %0d want 7", bus.cnt_live);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL level_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (bus.sticky_out !== 4'b0011) begin
      errors++;
      $display("FAIL level_sticky: got %b want 0011", bus.sticky_out);
    end
  endtask

  task automatic test_sticky();
    bus.sticky_clr = 4'b0001;
    tick();
    bus.sticky_clr = 4'b0000;
    checks++;
    if (bus.sticky_out !== 4'b0010) begin
      errors++;
      $display("FAIL sticky_clr: got %b want 0010", bus.sticky_out);
    end
    bus.ev_in      = 4'b0010;
    bus.sticky_clr = 4'b0010;
    tick();
    bus.sticky_clr = 4'b0000;
    bus.ev_in      = 4'b0000;
    checks++;
    if (bus.sticky_out !== 4'b0010) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b want 0010", bus.sticky_out);
    end
    tick();
  endtask

  task automatic test_wrap();
    bw.rise_en = 1'b1;
    bs.rise_en = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      bw.ev_in = 1'b1;
      bs.ev_in = 1'b1;
      tick();
      bw.ev_in = 1'b0;
      bs.ev_in = 1'b0;
      tick();
      if (e == 15) begin
        checks++;
        if (bw.cnt_live !== 4'd15 || bw.ovf !== 1'b0 ||
            bs.cnt_live !== 4'd15 || bs.ovf !== 1'b0) begin
          errors++;
          $display("FAIL wrap_at_max: w %0d/%b s %0d/%b want 15/0",
                   bw.cnt_live, bw.ovf, bs.cnt_live, bs.ovf);
        end
      end
      if (e == 16) begin
        checks++;
        if (bw.cnt_live !== 4'd0 || bw.ovf !== 1'b1) begin
          errors++;
          $display("FAIL wrap_to_zero: got %0d/%b want 0/1",
                   bw.cnt_live, bw.ovf);
        end
      end
    end
    checks++;
    if (bw.cnt_live !== 4'd1 || bw.ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_17: got %0d/%b want 1/1", bw.cnt_live, bw.ovf);
    end
    checks++;
    if (bs.cnt_live !== 4'd15 || bs.ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_17: got %0d/%b want 15/1", bs.cnt_live, bs.ovf);
    end
  endtask

  task automatic test_clr();
    bus.rise_en = 4'b0101;
    bus.rd_sel  = 4'd2;
    for (int e = 0; e < 5; e++) begin
      bus.ev_in = 4'b0100;
      tick();
      bus.ev_in = 4'b0000;
      tick();
    end
    checks++;
    if (bus.cnt_live !== 32'd5) begin
      errors++;
      $display("FAIL clr_pre: got %0d want 5", bus.cnt_live);
    end
    bus.ev_in    = 4'b0100;
    bus.clr_trig = 4'b0100;
    tick();
    bus.clr_trig = 4'b0000;
    checks++;
    if (bus.cnt_live !== 32'd1 || bus.ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_rise: got %0d/%b want 1/0",
               bus.cnt_live, bus.ovf[2]);
    end
    bus.ev_in    = 4'b0000;
    bus.clr_trig = 4'b0100;
    tick();
    bus.clr_trig = 4'b0000;
    checks++;
    if (bus.cnt_live !== 32'd0) begin
      errors++;
      $display("FAIL clr_plain: got %0d want 0", bus.cnt_live);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] exp_live [4];
    logic [31:0] exp_snap [4];
    exp_live = '{32'd0, 32'd5, 32'd0, 32'd2};
    exp_snap = '{32'd9, 32'd4, 32'd0, 32'd2};
    bus.rise_en  = 4'b1111;
    bus.ev_in    = 4'b0000;
    bus.clr_trig = 4'b1111;
    tick();
    bus.clr_trig = 4'b0000;
    for (int k = 0; k < 9; k++) begin
      bus.ev_in = {(k < 2), 1'b0, (k < 4), 1'b1};
      tick();
      bus.ev_in = 4'b0000;
      tick();
    end
    bus.snap_trig = 1'b1;
    bus.clr_trig  = 4'b0001;
    bus.ev_in     = 4'b0010;
    tick();
    bus.snap_trig = 1'b0;
    bus.clr_trig  = 4'b0000;
    bus.ev_in     = 4'b0000;
    tick();
    for (int s = 0; s < 4; s++) begin
      bus.rd_sel = 4'(s);
      #1;
      checks++;
      if (bus.cnt_live !== exp_live[s] || bus.cnt_snap !== exp_snap[s]) begin
        errors++;
        $display("FAIL snap sel %0d: live %0d snap %0d want %0d %0d",
                 s, bus.cnt_live, bus.cnt_snap, exp_live[s], exp_snap[s]);
      end
    end
    bus.rd_sel = 4'd7;
    #1;
    checks++;
    if (bus.cnt_live !== 32'd0 || bus.cnt_snap !== 32'd0) begin
      errors++;
      $display("FAIL sel_oob: live %0d snap %0d want 0 0",
               bus.cnt_live, bus.cnt_snap);
    end
  endtask

  task automatic test_reset_midop();
    bus.rd_sel    = 4'd1;
    rst           = 1'b1;
    bus.ev_in     = 4'b1111;
    bus.snap_trig = 1'b1;
    tick();
    bus.snap_trig = 1'b0;
    checks++;
    if (bus.pulse_out !== 4'b0 || bus.sticky_out !== 4'b0 ||
        bus.ovf !== 4'b0 || bus.cnt_live !== 32'd0 ||
        bus.cnt_snap !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset: p %b s %b o %b live %0d snap %0d want 0",
               bus.pulse_out, bus.sticky_out, bus.ovf,
               bus.cnt_live, bus.cnt_snap);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.pulse_out !== 4'b0) begin
      errors++;
      $display("FAIL midop_release: pulse %b want 0", bus.pulse_out);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.ev_in      = '0;
    bus.rise_en    = '0;
    bus.clr_trig   = '0;
    bus.sticky_clr = '0;
    bus.snap_trig  = 1'b0;
    bus.rd_sel     = '0;
    bw.ev_in       = '0;
    bw.rise_en     = '0;
    bw.clr_trig    = '0;
    bw.sticky_clr  = '0;
    bw.snap_trig   = 1'b0;
    bw.rd_sel      = '0;
    bs.ev_in       = '0;
    bs.rise_en     = '0;
    bs.clr_trig    = '0;
    bs.sticky_clr  = '0;
    bs.snap_trig   = 1'b0;
    bs.rd_sel      = '0;
    test_reset();
    test_rise_count();
    test_level_count();
    test_sticky();
    test_wrap();
    test_clr();
    test_snapshot();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
